// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states, word width.
package mdu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdop_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  function automatic logic is_div(input mdop_t op);
    logic [1:0] v;
    v = op;
    return v[1];
  endfunction

  function automatic logic is_signed(input mdop_t op);
    logic [1:0] v;
    v = op;
    return ~v[0];
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift a dividend bit into the partial remainder and subtract if it fits.
module mdu_divstep
  import mdu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] trial;

  // rem_i < divisor_i always holds, so the difference fits in WIDTH bits.
  always_comb begin
    trial = {rem_i, bit_i};
    q_o   = (trial >= {1'b0, divisor_i});
    rem_o = q_o ? (trial[WIDTH-1:0] - divisor_i) : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit owning HI/LO. Define MDU_EARLY_EN to let multiplies
// leave CALC as soon as the remaining multiplier bits are all zero.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  mdop_t            mdop,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  input  logic             flush,
  input  logic             hiWEN,
  input  logic             loWEN,
  input  logic [WIDTH-1:0] wdat,
  output logic             busy,
  output logic             done,
  output logic             divZ,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH);

  state_t             state_q;
  mdop_t              op_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] b_q, b_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               neg_lo_q, neg_hi_q, divz_q;
  logic               busy_q, done_q, divz_out_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               sign_a, sign_b, last_step, ds_q;
  logic [WIDTH-1:0]   abs_a, abs_b, ds_rem, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  // a_q: multiplier (shifts right) or dividend shifting out / quotient shifting in.
  // b_q: multiplicand (shifts left) or divisor in the low half.
  // p_q: product accumulator or partial remainder in the low half.
  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i     (p_q[WIDTH-1:0]),
    .bit_i     (a_q[WIDTH-1]),
    .divisor_i (b_q[WIDTH-1:0]),
    .rem_o     (ds_rem),
    .q_o       (ds_q)
  );

  always_comb begin
    sign_a = is_signed(mdop) & portA[WIDTH-1];
    sign_b = is_signed(mdop) & portB[WIDTH-1];
    abs_a  = sign_a ? -portA : portA;
    abs_b  = sign_b ? -portB : portB;

    if (is_div(op_q)) begin
      a_d = {a_q[WIDTH-2:0], ds_q};
      b_d = b_q;
      p_d = {{WIDTH{1'b0}}, ds_rem};
    end else begin
      a_d = a_q >> 1;
      b_d = b_q << 1;
      p_d = a_q[0] ? (p_q + b_q) : p_q;
    end

    last_step = (cnt_q == CW'(WIDTH - 1));
`ifdef MDU_EARLY_EN
    if (!is_div(op_q) && (a_d == '0)) last_step = 1'b1;
`endif

    prod_fix = neg_lo_q ? -p_q : p_q;
    quot_fix = divz_q ? '1 : (neg_lo_q ? -a_q : a_q);
    rem_fix  = neg_hi_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      op_q       <= MULT;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      divz_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      divz_out_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      divz_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hiWEN) hi_q <= wdat;
          if (loWEN) lo_q <= wdat;
          if (start && !flush) begin
            state_q  <= CALC;
            busy_q   <= 1'b1;
            op_q     <= mdop;
            cnt_q    <= '0;
            p_q      <= '0;
            neg_lo_q <= sign_a ^ sign_b;
            if (is_div(mdop)) begin
              a_q      <= abs_a;
              b_q      <= {{WIDTH{1'b0}}, abs_b};
              neg_hi_q <= sign_a;
              divz_q   <= (portB == '0);
            end else begin
              a_q      <= abs_b;
              b_q      <= {{WIDTH{1'b0}}, abs_a};
              neg_hi_q <= 1'b0;
              divz_q   <= 1'b0;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            cnt_q <= cnt_q + CW'(1);
            if (last_step) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            done_q     <= 1'b1;
            divz_out_q <= divz_q;
            if (is_div(op_q)) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign divZ      = divz_out_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule
